rpn_stack_param: RTL and testbench

Parametrised operand stack for the RPN calculator datapath, successor to the fixed 16-bit stack. Supports a combined pop-then-push per cycle (pop 0–2 entries, optionally push one), and exposes the top two entries for the ALU. Adds configurable width and depth, an occupancy count, full/empty status, and sticky overflow/underflow error flags. Illegal operations are rejected atomically, with no partial state change. Sits between the UART token parser (push side) and the ALU (consumes `first`/`second`, pushes the result).

---
 rtl/rpn_stack_param.sv | 99 +++++++++
 tb/tb_rpn_stack_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_param.sv
// Parametrised RPN operand stack.
// Each cycle can pop 0-2 entries and then optionally push one entry.
// An illegal operation is rejected as a whole and sets a sticky error flag.
// first/second are muxed straight out of the storage registers, so they
// change only on a clock edge.
module rpn_stack_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       pop_cnt,
    input  logic             clr,
    output logic [WIDTH-1:0] first,
    output logic [WIDTH-1:0] second,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             underflow,
    output logic             overflow
);

    // Count arithmetic uses one spare bit, so an overflowing push can never wrap.
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt;
    logic             uf_flag;
    logic             of_flag;

    logic [CW:0] cnt_ext;
    logic [CW:0] n_ext;
    logic [CW:0] p_ext;
    logic [CW:0] base_pos;
    logic [CW:0] new_cnt;
    logic [CW:0] top_pos;
    logic [CW:0] sec_pos;
    logic        uf_case;
    logic        of_case;
    logic        accept;
    logic        do_write;

    // Decode the requested operation and decide whether it is legal.
    always_comb begin
        cnt_ext  = {1'b0, cnt};
        n_ext    = (CW + 1)'(pop_cnt);
        p_ext    = (CW + 1)'(wen);
        base_pos = cnt_ext - n_ext;
        new_cnt  = base_pos + p_ext;
        uf_case  = (pop_cnt == 2'd3) || (n_ext > cnt_ext);
        of_case  = !uf_case && (new_cnt > DEPTH_C);
        accept   = !uf_case && !of_case;
        do_write = accept && wen && !rst && !clr;
    end

    // Update occupancy and the sticky error flags; rst beats clr, and clr beats the operation.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt     <= '0;
            uf_flag <= 1'b0;
            of_flag <= 1'b0;
        end else begin
            if (uf_case) uf_flag <= 1'b1;
            if (of_case) of_flag <= 1'b1;
            if (accept)  cnt     <= new_cnt[CW-1:0];
        end
    end

    // Write the pushed value into the slot just above the remaining entries.
    // The contents are not reset, because the read mux masks every slot at or above count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_write && (base_pos == (CW + 1)'(i))) mem[i] <= din;
        end
    end

    // Select the top two entries.
    // When count is below 1 or 2, the position wraps to a large value that matches no slot.
    always_comb begin
        top_pos = cnt_ext - (CW + 1)'(1);
        sec_pos = cnt_ext - (CW + 1)'(2);
        first   = '0;
        second  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (top_pos == (CW + 1)'(i)) first  = mem[i];
            if (sec_pos == (CW + 1)'(i)) second = mem[i];
        end
    end

    assign count     = cnt;
    assign empty     = (cnt == '0);
    assign full      = (cnt == DEPTH_C[CW-1:0]);
    assign underflow = uf_flag;
    assign overflow  = of_flag;

endmodule

// File: tb/tb_rpn_stack_param.sv
// Bench for rpn_stack_param.
// Two instances share the same inputs: A is 32 bits wide and 16 deep, B is 32 bits wide and 4 deep.
// Each instance is compared against its own stack model after every edge.
module tb_rpn_stack_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wen = 1'b0;
    logic [1:0]  pop_cnt = 2'd0;
    logic [31:0] din = '0;

    logic [31:0] first_a, second_a, first_b, second_b;
    logic [4:0]  count_a;
    logic [2:0]  count_b;
    logic        empty_a, full_a, uf_a, of_a;
    logic        empty_b, full_b, uf_b, of_b;

    int checks = 0;
    int errors = 0;

    // Model state: a plain array used as a stack, plus occupancy and the two flags.
    int          dep [2] = '{16, 4};
    int          mcnt[2];
    logic [31:0] mdat[2][16];
    bit          muf [2];
    bit          mof [2];

    rpn_stack_param #(.WIDTH(32), .DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .wen(wen), .din(din), .pop_cnt(pop_cnt), .clr(clr),
        .first(first_a), .second(second_a), .count(count_a), .empty(empty_a),
        .full(full_a), .underflow(uf_a), .overflow(of_a)
    );

    rpn_stack_param #(.WIDTH(32), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .wen(wen), .din(din), .pop_cnt(pop_cnt), .clr(clr),
        .first(first_b), .second(second_b), .count(count_b), .empty(empty_b),
        .full(full_b), .underflow(uf_b), .overflow(of_b)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit c, input bit w, input int n,
                              input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            if (r || c) begin
                mcnt[k] = 0;
                muf[k]  = 1'b0;
                mof[k]  = 1'b0;
            end else if (n == 3 || n > mcnt[k]) begin
                muf[k] = 1'b1;
            end else if (mcnt[k] - n + (w ? 1 : 0) > dep[k]) begin
                mof[k] = 1'b1;
            end else begin
                mcnt[k] = mcnt[k] - n;
                if (w) begin
                    mdat[k][mcnt[k]] = d;
                    mcnt[k] = mcnt[k] + 1;
                end
            end
        end
    endtask

    function automatic logic [31:0] exp_first(input int k);
        return (mcnt[k] >= 1) ? mdat[k][mcnt[k]-1] : 32'd0;
    endfunction

    function automatic logic [31:0] exp_second(input int k);
        return (mcnt[k] >= 2) ? mdat[k][mcnt[k]-2] : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("first_a",  first_a,  exp_first(0));
        chk("second_a", second_a, exp_second(0));
        chk("count_a",  32'(count_a), 32'(mcnt[0]));
        chk("empty_a",  32'(empty_a), 32'(mcnt[0] == 0));
        chk("full_a",   32'(full_a),  32'(mcnt[0] == dep[0]));
        chk("uf_a",     32'(uf_a),    32'(muf[0]));
        chk("of_a",     32'(of_a),    32'(mof[0]));
        chk("first_b",  first_b,  exp_first(1));
        chk("second_b", second_b, exp_second(1));
        chk("count_b",  32'(count_b), 32'(mcnt[1]));
        chk("empty_b",  32'(empty_b), 32'(mcnt[1] == 0));
        chk("full_b",   32'(full_b),  32'(mcnt[1] == dep[1]));
        chk("uf_b",     32'(uf_b),    32'(muf[1]));
        chk("of_b",     32'(of_b),    32'(mof[1]));
    endtask

    // Present one operation, let the edge take it, update the model, then sample #1 later.
    task automatic op(input bit r, input bit c, input bit w, input int n, input logic [31:0] d);
        rst     = r;
        clr     = c;
        wen     = w;
        pop_cnt = n[1:0];
        din     = d;
        @(posedge clk);
        model_step(r, c, w, n, d);
        #1;
        check_all();
    endtask

    task automatic push(input logic [31:0] d);
        op(1'b0, 1'b0, 1'b1, 0, d);
    endtask

    initial begin
        // Reset state
        op(1'b1, 1'b0, 1'b0, 0, 0);
        chk("rst_count_a", 32'(count_a), 0);
        chk("rst_empty_a", 32'(empty_a), 1);

        // Basic sequence
        push(1);
        chk("basic1_first", first_a, 1);
        op(1'b0, 1'b0, 1'b0, 1, 0);
        chk("basic2_count", 32'(count_a), 0);
        push(2);
        push(3);
        chk("basic4_second", second_a, 2);
        op(1'b0, 1'b0, 1'b1, 1, 4);
        chk("basic5_first", first_a, 4);
        op(1'b0, 1'b0, 1'b1, 2, 5);
        chk("basic6_first", first_a, 5);
        chk("basic6_count", 32'(count_a), 1);
        chk("basic6_noflag", 32'({uf_a, of_a}), 0);

        // Underflow
        op(1'b1, 1'b0, 1'b0, 0, 0);
        op(1'b0, 1'b0, 1'b0, 1, 0);
        chk("uf_set", 32'(uf_a), 1);
        push(7);
        chk("uf_sticky", 32'(uf_a), 1);
        op(1'b0, 1'b0, 1'b1, 3, 32'h55);
        chk("uf_pop3_first", first_a, 7);

        // Overflow on the 4-deep instance
        op(1'b1, 1'b0, 1'b0, 0, 0);
        push(10); push(11); push(12); push(13);
        chk("ovf_full", 32'(full_b), 1);
        push(14);
        chk("ovf_flag", 32'(of_b), 1);
        chk("ovf_first", first_b, 13);
        op(1'b0, 1'b0, 1'b1, 1, 14);
        chk("ovf_repl_first", first_b, 14);
        chk("ovf_repl_second", second_b, 12);
        chk("ovf_repl_count", 32'(count_b), 4);

        // Replace at full with two pops
        op(1'b1, 1'b0, 1'b0, 0, 0);
        push(10); push(11); push(12); push(13);
        op(1'b0, 1'b0, 1'b1, 2, 99);
        chk("repl2_count", 32'(count_b), 3);
        chk("repl2_first", first_b, 99);
        chk("repl2_second", second_b, 11);

        // Clear wins over a simultaneous push
        op(1'b1, 1'b0, 1'b0, 0, 0);
        op(1'b0, 1'b0, 1'b0, 1, 0);
        push(1); push(2); push(3); push(4); push(5);
        chk("clr_pre_uf", 32'(uf_b), 1);
        chk("clr_pre_of", 32'(of_b), 1);
        op(1'b0, 1'b1, 1'b1, 0, 5);
        chk("clr_count", 32'(count_b), 0);
        chk("clr_flags", 32'({uf_b, of_b}), 0);
        chk("clr_first", first_b, 0);

        // Reset in the middle of a sequence
        push(1); push(2); push(3);
        op(1'b1, 1'b0, 1'b1, 0, 9);
        chk("rstmid_count", 32'(count_a), 0);
        chk("rstmid_first", first_a, 0);
        push(8);
        chk("rstmid_push", first_a, 8);

        // Full 32-bit values
        push(32'hDEADBEEF);
        push(32'h1);
        chk("width_first", first_a, 32'h1);
        chk("width_second", second_a, 32'hDEADBEEF);

        // Random operations compared against the model
        for (int it = 0; it < 400; it++) begin
            int  sel;
            int  n;
            bit  r, c, w;
            sel = int'($urandom_range(0, 9));
            n   = (sel < 5) ? 0 : (sel < 8) ? 1 : (sel == 8) ? 2 : 3;
            r   = ($urandom_range(0, 79) == 0);
            c   = ($urandom_range(0, 49) == 0);
            w   = ($urandom_range(0, 2) != 0);
            op(r, c, w, n, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
